// File: rtl/cpusnoop_fifo.sv
// CPU write snoop for the Mac SE frame buffer. Queues 68000 writes that hit the
// active buffer and drains them into VRAM in the free pixel-sequence slots.
module cpusnoop_fifo #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          LVL_W      = 3,
  parameter logic [13:0] BUF_OFFSET = 14'h1380,
  parameter int          LAST_SLOT  = 5
) (
  input  logic             pixClock,
  input  logic             nReset,
  input  logic [2:0]       seq,
  input  logic [22:0]      cpuAddr,
  input  logic [15:0]      cpuData,
  input  logic             ncpuAS,
  input  logic             ncpuUDS,
  input  logic             ncpuLDS,
  input  logic             cpuRnW,
  input  logic [2:0]       ramSize,
  input  logic             altBuf,
  output logic [14:0]      vramAddr,
  output logic [7:0]       vramDataOut,
  output logic             nvramWE,
  output logic [LVL_W-1:0] fifoLevel,
  output logic             overflow
);

  localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       SLOT     = 3'(LAST_SLOT);

  typedef enum logic [1:0] {C_IDLE, C_ARM, C_WAIT} capState_t;
  typedef enum logic [1:0] {D_IDLE, D_LO, D_HI} drnState_t;

  capState_t capState, capNext;
  drnState_t drnState, drnNext;

  logic [13:0] entAddr [FIFO_DEPTH];
  logic        entHiV  [FIFO_DEPTH];
  logic        entLoV  [FIFO_DEPTH];
  logic [15:0] entData [FIFO_DEPTH];

  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [LVL_W-1:0] level;

  logic        bufHit, strobe, pushReq, popReq, pushOk, pushDrop, full, empty;
  logic [13:0] headAddr;
  logic        headHiV, headLoV;
  logic [15:0] headData;

  assign bufHit = (cpuAddr[22:21] == 2'b00) &&
                  (cpuAddr[20:18] == ramSize) &&
                  (cpuAddr[17:14] == (altBuf ? 4'hE : 4'hF));

  assign strobe = !ncpuUDS || !ncpuLDS;

  assign full      = (level == FULL_LVL);
  assign empty     = (level == '0);
  assign fifoLevel = level;

  assign headAddr = entAddr[rdPtr];
  assign headHiV  = entHiV[rdPtr];
  assign headLoV  = entLoV[rdPtr];
  assign headData = entData[rdPtr];

  // Capture FSM: one push per CPU bus cycle
  always_ff @(negedge pixClock or negedge nReset) begin
    if (!nReset) capState <= C_IDLE;
    else         capState <= capNext;
  end

  always_comb begin
    capNext = capState;
    case (capState)
      C_IDLE: if (!ncpuAS && bufHit && !cpuRnW) capNext = C_ARM;
      C_ARM: begin
        if (strobe)      capNext = C_WAIT;
        else if (ncpuAS) capNext = C_IDLE;
      end
      C_WAIT: if (ncpuUDS && ncpuLDS && ncpuAS) capNext = C_IDLE;
      default: capNext = C_IDLE;
    endcase
  end

  always_comb begin
    pushReq = (capState == C_ARM) && strobe;
  end

  // Drain FSM: lo byte first, one idle cycle between entries
  always_ff @(negedge pixClock or negedge nReset) begin
    if (!nReset) drnState <= D_IDLE;
    else         drnState <= drnNext;
  end

  always_comb begin
    drnNext = drnState;
    case (drnState)
      D_IDLE: begin
        if (!empty) begin
          if (headLoV && headHiV) begin
            if (seq < SLOT) drnNext = D_LO;
          end else if (seq <= SLOT) begin
            drnNext = headLoV ? D_LO : D_HI;
          end
        end
      end
      D_LO:    drnNext = headHiV ? D_HI : D_IDLE;
      D_HI:    drnNext = D_IDLE;
      default: drnNext = D_IDLE;
    endcase
  end

  always_comb begin
    popReq      = 1'b0;
    nvramWE     = 1'b1;
    vramDataOut = 8'h00;
    vramAddr    = empty ? 15'd0 : {headAddr, 1'b0};
    case (drnState)
      D_LO: begin
        nvramWE     = 1'b0;
        vramAddr    = {headAddr, 1'b0};
        vramDataOut = headData[7:0];
        popReq      = !headHiV;
      end
      D_HI: begin
        nvramWE     = 1'b0;
        vramAddr    = {headAddr, 1'b1};
        vramDataOut = headData[15:8];
        popReq      = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping; a pop on the same edge frees a slot for a push when full
  assign pushOk   = pushReq && (!full || popReq);
  assign pushDrop = pushReq && full && !popReq;

  always_ff @(negedge pixClock or negedge nReset) begin
    if (!nReset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popReq) rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popReq})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (pushDrop) overflow <= 1'b1;
    end
  end

  always_ff @(negedge pixClock) begin
    if (pushOk) begin
      entAddr[wrPtr] <= cpuAddr[13:0] - BUF_OFFSET;
      entHiV[wrPtr]  <= !ncpuUDS;
      entLoV[wrPtr]  <= !ncpuLDS;
      entData[wrPtr] <= cpuData;
    end
  end

endmodule
